// File: rtl/sim_dev_pkg.sv
// rtl/sim_dev_pkg.sv - shared types and encodings for the SimDev request port
package sim_dev_pkg;

  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_4B = 2'd2;

  localparam logic FUNC_READ  = 1'b0;
  localparam logic FUNC_WRITE = 1'b1;

  typedef struct packed {
    logic        is_cached;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
    logic        func;
    logic [3:0]  strb;
  } dev_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sim_dev_arbiter_rr_pick2.sv
// rtl/sim_dev_arbiter_rr_pick2.sv - combinational 2-way round-robin / fixed-priority picker
module rr_pick2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic       o_grant,
  output logic       o_any
);

  assign o_any = |i_valid;

  // On a tie, round-robin hands the grant to whoever did not win last time.
  always_comb begin
    o_grant = i_valid[1];
    if (&i_valid) begin
      o_grant = (FIXED_PRIO != 0) ? 1'b1 : ~i_last;
    end
  end

endmodule

// File: rtl/sim_dev_arbiter.sv
// rtl/sim_dev_arbiter.sv - 2:1 arbiter sharing the SimDev port between fetch (in0) and data (in1)
module sim_dev_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clock,
  input  logic        reset,

  output logic        in0_req_ready,
  input  logic        in0_req_valid,
  input  logic        in0_req_bits_is_cached,
  input  logic [31:0] in0_req_bits_addr,
  input  logic [1:0]  in0_req_bits_len,
  input  logic [31:0] in0_req_bits_data,
  input  logic        in0_req_bits_func,
  input  logic [3:0]  in0_req_bits_strb,
  input  logic        in0_resp_ready,
  output logic        in0_resp_valid,
  output logic [31:0] in0_resp_bits_data,

  output logic        in1_req_ready,
  input  logic        in1_req_valid,
  input  logic        in1_req_bits_is_cached,
  input  logic [31:0] in1_req_bits_addr,
  input  logic [1:0]  in1_req_bits_len,
  input  logic [31:0] in1_req_bits_data,
  input  logic        in1_req_bits_func,
  input  logic [3:0]  in1_req_bits_strb,
  input  logic        in1_resp_ready,
  output logic        in1_resp_valid,
  output logic [31:0] in1_resp_bits_data,

  input  logic        out_req_ready,
  output logic        out_req_valid,
  output logic        out_req_bits_is_cached,
  output logic [31:0] out_req_bits_addr,
  output logic [1:0]  out_req_bits_len,
  output logic [31:0] out_req_bits_data,
  output logic        out_req_bits_func,
  output logic [3:0]  out_req_bits_strb,
  output logic        out_resp_ready,
  input  logic        out_resp_valid,
  input  logic [31:0] out_resp_bits_data
);

  import sim_dev_pkg::*;

  arb_state_e r_state;
  logic       r_owner;
  logic       r_last;
  dev_req_t   r_payload;

  logic       w_grant;
  logic       w_any;
  logic       w_idle;
  logic       w_issue;
  logic       w_wait;
  logic       w_owner_resp_ready;
  logic       w_resp_fire;
  dev_req_t   w_in0_req;
  dev_req_t   w_in1_req;
  dev_req_t   w_out_req;

  assign w_in0_req = '{is_cached: in0_req_bits_is_cached, addr: in0_req_bits_addr,
                       len: in0_req_bits_len, data: in0_req_bits_data,
                       func: in0_req_bits_func, strb: in0_req_bits_strb};
  assign w_in1_req = '{is_cached: in1_req_bits_is_cached, addr: in1_req_bits_addr,
                       len: in1_req_bits_len, data: in1_req_bits_data,
                       func: in1_req_bits_func, strb: in1_req_bits_strb};

  rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .i_valid ({in1_req_valid, in0_req_valid}),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_any   (w_any)
  );

  // Every output is forced low while reset is held, even in the reset cycle itself.
  assign w_idle  = !reset && (r_state == IDLE);
  assign w_issue = !reset && (r_state == ISSUE);
  assign w_wait  = !reset && (r_state == WAIT);

  assign w_owner_resp_ready = r_owner ? in1_resp_ready : in0_resp_ready;
  assign w_resp_fire        = out_resp_valid && out_resp_ready;

  assign in0_req_ready = w_idle && w_any && !w_grant;
  assign in1_req_ready = w_idle && w_any &&  w_grant;

  assign out_req_valid          = w_issue;
  assign w_out_req              = reset ? '0 : r_payload;
  assign out_req_bits_is_cached = w_out_req.is_cached;
  assign out_req_bits_addr      = w_out_req.addr;
  assign out_req_bits_len       = w_out_req.len;
  assign out_req_bits_data      = w_out_req.data;
  assign out_req_bits_func      = w_out_req.func;
  assign out_req_bits_strb      = w_out_req.strb;

  assign out_resp_ready     = w_wait && w_owner_resp_ready;
  assign in0_resp_valid     = w_wait && !r_owner && out_resp_valid;
  assign in1_resp_valid     = w_wait &&  r_owner && out_resp_valid;
  assign in0_resp_bits_data = (w_wait && !r_owner) ? out_resp_bits_data : 32'd0;
  assign in1_resp_bits_data = (w_wait &&  r_owner) ? out_resp_bits_data : 32'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_payload <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_payload <= w_grant ? w_in1_req : w_in0_req;
          r_owner   <= w_grant;
          r_last    <= w_grant;
          r_state   <= ISSUE;
        end
        ISSUE: if (out_req_ready) r_state <= WAIT;
        WAIT:  if (w_resp_fire)   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // A device response with no transaction waiting for it is a protocol violation.
  always_ff @(posedge clock) begin
    if (!reset && r_state != WAIT) assert (!out_resp_valid);
  end

endmodule

// File: tb/tb_sim_dev_arbiter.sv
// tb/tb_sim_dev_arbiter.sv - directed scoreboard bench for sim_dev_arbiter (round-robin and fixed-priority)
module tb_sim_dev_arbiter;
  import sim_dev_pkg::*;

  typedef struct {
    int          owner;
    dev_req_t    req;
    logic [31:0] rdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid  [2][2];
  logic        req_ready  [2][2];
  logic        resp_ready [2][2];
  logic        resp_valid [2][2];
  logic [31:0] resp_data  [2][2];
  dev_req_t    req_bits   [2][2];
  logic        out_req_ready  [2];
  logic        out_req_valid  [2];
  logic        out_resp_ready [2];
  logic        out_resp_valid [2];
  logic [31:0] out_resp_data  [2];
  logic        o_cached [2];
  logic [31:0] o_addr   [2];
  logic [1:0]  o_len    [2];
  logic [31:0] o_data   [2];
  logic        o_func   [2];
  logic [3:0]  o_strb   [2];
  logic [1:0]  st       [2];

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    sim_dev_arbiter #(.FIXED_PRIO(g)) u_dut (
      .clock                  (clock),
      .reset                  (reset),
      .in0_req_ready          (req_ready[g][0]),
      .in0_req_valid          (req_valid[g][0]),
      .in0_req_bits_is_cached (req_bits[g][0].is_cached),
      .in0_req_bits_addr      (req_bits[g][0].addr),
      .in0_req_bits_len       (req_bits[g][0].len),
      .in0_req_bits_data      (req_bits[g][0].data),
      .in0_req_bits_func      (req_bits[g][0].func),
      .in0_req_bits_strb      (req_bits[g][0].strb),
      .in0_resp_ready         (resp_ready[g][0]),
      .in0_resp_valid         (resp_valid[g][0]),
      .in0_resp_bits_data     (resp_data[g][0]),
      .in1_req_ready          (req_ready[g][1]),
      .in1_req_valid          (req_valid[g][1]),
      .in1_req_bits_is_cached (req_bits[g][1].is_cached),
      .in1_req_bits_addr      (req_bits[g][1].addr),
      .in1_req_bits_len       (req_bits[g][1].len),
      .in1_req_bits_data      (req_bits[g][1].data),
      .in1_req_bits_func      (req_bits[g][1].func),
      .in1_req_bits_strb      (req_bits[g][1].strb),
      .in1_resp_ready         (resp_ready[g][1]),
      .in1_resp_valid         (resp_valid[g][1]),
      .in1_resp_bits_data     (resp_data[g][1]),
      .out_req_ready          (out_req_ready[g]),
      .out_req_valid          (out_req_valid[g]),
      .out_req_bits_is_cached (o_cached[g]),
      .out_req_bits_addr      (o_addr[g]),
      .out_req_bits_len       (o_len[g]),
      .out_req_bits_data      (o_data[g]),
      .out_req_bits_func      (o_func[g]),
      .out_req_bits_strb      (o_strb[g]),
      .out_resp_ready         (out_resp_ready[g]),
      .out_resp_valid         (out_resp_valid[g]),
      .out_resp_bits_data     (out_resp_data[g])
    );
    assign st[g] = u_dut.r_state;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic dev_req_t mk(input logic [31:0] a, input logic [1:0] l, input logic [31:0] dt,
                                  input logic f, input logic [3:0] s, input logic c);
    mk = '{is_cached: c, addr: a, len: l, data: dt, func: f, strb: s};
  endfunction

  task automatic push(input int owner, input dev_req_t r, input logic [31:0] rdata);
    exp_t e;
    e.owner = owner;
    e.req   = r;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic check_req(input int d, input exp_t e);
    chk("out_req_valid", out_req_valid[d], 1'b1);
    chk("out_addr", o_addr[d], e.req.addr);
    chk("out_data", o_data[d], e.req.data);
    chk("out_strb", o_strb[d], e.req.strb);
    chk("out_len", o_len[d], e.req.len);
    chk("out_func", o_func[d], e.req.func);
    chk("out_cached", o_cached[d], e.req.is_cached);
  endtask

  // Plays the device: waits for the next request, checks it against the scoreboard, responds.
  task automatic serve(input int d, input int hold_ready, input int hold_resp);
    exp_t e;
    int   n;
    int   o;
    n = 0;
    while (out_req_valid[d] !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk("req_wait", out_req_valid[d], 1'b1);
    chk("sb_nonempty", sb.size() > 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    o = e.owner;
    out_req_ready[d] = 1'b0;
    for (int i = 0; i < hold_ready; i++) begin
      check_req(d, e);
      chk("issue_st", st[d], ISSUE);
      cyc();
    end
    check_req(d, e);
    out_req_ready[d] = 1'b1;
    cyc();
    out_req_ready[d] = 1'b0;
    for (int i = 0; i < hold_resp; i++) begin
      resp_ready[d][o]  = 1'b0;
      out_resp_valid[d] = 1'b1;
      out_resp_data[d]  = e.rdata;
      #1;
      chk("bp_resp_ready", out_resp_ready[d], 1'b0);
      chk("bp_wait_st", st[d], WAIT);
      cyc();
    end
    resp_ready[d][o]  = 1'b1;
    out_resp_valid[d] = 1'b1;
    out_resp_data[d]  = e.rdata;
    #1;
    chk("owner_resp_valid", resp_valid[d][o], 1'b1);
    chk("owner_resp_data", resp_data[d][o], e.rdata);
    chk("other_resp_valid", resp_valid[d][1-o], 1'b0);
    chk("out_resp_ready", out_resp_ready[d], 1'b1);
    cyc();
    out_resp_valid[d] = 1'b0;
    out_resp_data[d]  = 32'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dev_req_t r;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      out_req_ready[d]  = 1'b0;
      out_resp_valid[d] = 1'b0;
      out_resp_data[d]  = 32'd0;
      for (int p = 0; p < 2; p++) begin
        req_valid[d][p]  = 1'b0;
        resp_ready[d][p] = 1'b1;
        req_bits[d][p]   = '0;
      end
    end

    // Reset: outputs low even with requests pending.
    cyc();
    req_valid[0][0] = 1'b1;
    req_valid[0][1] = 1'b1;
    #1;
    chk("rst_in0_ready", req_ready[0][0], 1'b0);
    chk("rst_in1_ready", req_ready[0][1], 1'b0);
    chk("rst_out_req_valid", out_req_valid[0], 1'b0);
    chk("rst_out_resp_ready", out_resp_ready[0], 1'b0);
    chk("rst_resp_valid", resp_valid[0][0], 1'b0);
    chk("rst_addr", o_addr[0], 32'd0);
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b0;
    cyc();
    reset = 1'b0;

    // Single read from in0.
    r = mk(32'h1000, LEN_4B, 32'd0, FUNC_READ, 4'hF, 1'b0);
    req_bits[0][0]  = r;
    req_valid[0][0] = 1'b1;
    #1;
    chk("rd_in0_ready", req_ready[0][0], 1'b1);
    chk("rd_in1_ready", req_ready[0][1], 1'b0);
    push(0, r, 32'hDEADBEEF);
    cyc();
    req_valid[0][0] = 1'b0;
    chk("rd_t1_valid", out_req_valid[0], 1'b1);
    chk("rd_t1_addr", o_addr[0], 32'h1000);
    serve(0, 0, 0);
    chk("rd_single_pulse", resp_valid[0][0], 1'b0);

    // Round-robin tie from reset: in0, in1, in0, in1.
    do_reset();
    req_bits[0][0]  = mk(32'h100, LEN_4B, 32'd0, FUNC_READ, 4'hF, 1'b1);
    req_bits[0][1]  = mk(32'h200, LEN_4B, 32'd0, FUNC_READ, 4'hF, 1'b0);
    req_valid[0][0] = 1'b1;
    req_valid[0][1] = 1'b1;
    #1;
    chk("rr_first_in0_ready", req_ready[0][0], 1'b1);
    chk("rr_first_in1_ready", req_ready[0][1], 1'b0);
    for (int k = 0; k < 4; k++) push(k % 2, req_bits[0][k % 2], 32'hA000 + k);
    for (int k = 0; k < 4; k++) serve(0, 0, 0);
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b0;

    // Backpressure on both the request and response side; payload changes after accept.
    r = mk(32'h2004, LEN_4B, 32'h12345678, FUNC_WRITE, 4'hF, 1'b1);
    req_bits[0][0]  = r;
    req_valid[0][0] = 1'b1;
    push(0, r, 32'h55AA00FF);
    cyc();
    req_valid[0][0] = 1'b0;
    req_bits[0][0]  = mk(32'hFFFF0000, LEN_1B, 32'h0, FUNC_READ, 4'h0, 1'b0);
    serve(0, 5, 3);

    // Reset one cycle after the request handshake drops the transaction.
    r = mk(32'h4000, LEN_4B, 32'd0, FUNC_READ, 4'hF, 1'b0);
    req_bits[0][0]  = r;
    req_valid[0][0] = 1'b1;
    cyc();
    req_valid[0][0] = 1'b0;
    chk("mid_out_req_valid", out_req_valid[0], 1'b1);
    out_req_ready[0] = 1'b1;
    cyc();
    out_req_ready[0] = 1'b0;
    chk("mid_st_wait", st[0], WAIT);
    reset = 1'b1;
    req_bits[0][1]  = mk(32'h4400, LEN_4B, 32'd0, FUNC_READ, 4'hF, 1'b0);
    req_valid[0][0] = 1'b1;
    req_valid[0][1] = 1'b1;
    cyc();
    chk("mid_rst_in0_ready", req_ready[0][0], 1'b0);
    chk("mid_rst_in1_ready", req_ready[0][1], 1'b0);
    chk("mid_rst_out_req_valid", out_req_valid[0], 1'b0);
    chk("mid_rst_out_resp_ready", out_resp_ready[0], 1'b0);
    chk("mid_rst_resp_valid", resp_valid[0][0], 1'b0);
    chk("mid_rst_st", st[0], IDLE);
    reset = 1'b0;
    #1;
    chk("post_rst_in0_ready", req_ready[0][0], 1'b1);
    chk("post_rst_in1_ready", req_ready[0][1], 1'b0);
    push(0, r, 32'h0BADF00D);
    cyc();
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b0;
    serve(0, 0, 0);

    // Write from in1: one request on the device, one response pulse.
    r = mk(32'h3002, LEN_2B, 32'hABCD, FUNC_WRITE, 4'h3, 1'b0);
    req_bits[0][1]  = r;
    req_valid[0][1] = 1'b1;
    push(1, r, 32'h0);
    cyc();
    req_valid[0][1] = 1'b0;
    serve(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("wr_no_repeat", out_req_valid[0], 1'b0);
      chk("wr_no_second_resp", resp_valid[0][1], 1'b0);
      cyc();
    end

    // Fixed priority: in1 wins every tie, in0 only after in1 drops.
    do_reset();
    req_bits[1][0]  = mk(32'h500, LEN_4B, 32'd0, FUNC_READ, 4'hF, 1'b0);
    req_bits[1][1]  = mk(32'h600, LEN_4B, 32'd0, FUNC_READ, 4'hF, 1'b1);
    req_valid[1][0] = 1'b1;
    req_valid[1][1] = 1'b1;
    #1;
    chk("fp_in1_ready", req_ready[1][1], 1'b1);
    chk("fp_in0_ready", req_ready[1][0], 1'b0);
    for (int k = 0; k < 3; k++) push(1, req_bits[1][1], 32'hB000 + k);
    for (int k = 0; k < 3; k++) serve(1, 0, 0);
    req_valid[1][1] = 1'b0;
    push(0, req_bits[1][0], 32'hC000);
    serve(1, 0, 0);
    req_valid[1][0] = 1'b0;
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
